// File: rtl/bus_arb8.sv
// bus_arb8: 8-requester round-robin arbiter feeding a one-entry registered output buffer.
// Ports: clk, rst_n (async active-low); req[7:0] requests, din[8*WIDTH-1:0] packed requester data,
//   lock[7:0] grant-hold hints; ack[7:0] one-hot capture pulse, sel[2:0] last captured index,
//   out_valid/out_ready/out_data[WIDTH-1:0] output handshake.
// Define ARB_LOCK_EN to let a winner captured with lock[winner]=1 keep top priority.
module bus_arb8 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] din,
    input  logic [7:0]         lock,
    output logic [7:0]         ack,
    output logic [2:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t     state, state_nx;
    logic [2:0] last, start, win, idx;
    logic       slot, cap, hold;
    always_comb begin
        start = last + 3'd1;
`ifdef ARB_LOCK_EN
        if (hold) start = last;
`endif
        win = start;
        idx = start;
        // walk downward so the lowest offset from start is the final assignment
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (req[idx]) win = idx;
        end
        slot     = (state == EMPTY) || out_ready;
        cap      = slot && (|req);
        state_nx = cap ? FULL : (slot ? EMPTY : state);
        ack      = (cap && rst_n) ? (8'd1 << win) : 8'd0;
    end
    assign out_valid = (state == FULL);
`ifndef ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            sel      <= 3'd0;
            last     <= 3'd7;
            hold     <= 1'b0;
        end else begin
            state <= state_nx;
            if (cap) begin
                out_data <= din[win*WIDTH +: WIDTH];
                sel      <= win;
                last     <= win;
            end
`ifdef ARB_LOCK_EN
            if (cap) hold <= lock[win];
            else if (slot) hold <= 1'b0;
`else
            hold <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_bus_arb8.sv
// tb_bus_arb8: scoreboard bench for bus_arb8 with directed vectors.
module tb_bus_arb8;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   req, lock, ack;
    logic [127:0] din;
    logic [2:0]   sel;
    logic         out_valid, out_ready;
    logic [15:0]  out_data;
    int           n_chk = 0;
    int           n_fail = 0;
    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        logic [2:0]  s;
    } exp_t;
    exp_t q[$];
    exp_t cur;
    logic pend = 1'b0;
    bus_arb8 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din), .lock(lock), .ack(ack),
        .sel(sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic push(input logic [7:0] a, input logic [15:0] d, input logic [2:0] s);
        exp_t e;
        e.a = a; e.d = d; e.s = s;
        q.push_back(e);
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        cyc();
        rst_n = 1'b0; req = 8'h00; lock = 8'h00; out_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask
    // monitor: an ack pops the next expectation, the following cycle shows the captured word
    always @(negedge clk) begin
        if (pend) begin
            chk("cap_valid", 32'(out_valid), 32'd1);
            chk("cap_data", 32'(out_data), 32'(cur.d));
            chk("cap_sel", 32'(sel), 32'(cur.s));
            pend = 1'b0;
        end
        if (rst_n === 1'b1 && ack !== 8'h00) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                cur = q.pop_front();
                chk("ack", 32'(ack), 32'(cur.a));
                pend = 1'b1;
            end
        end
    end
    initial begin
        int exp_sel[5];
        rst_n = 1'b1; req = 8'h00; lock = 8'h00; din = '0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        req = 8'hFF;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        req = 8'h00;
        cyc();
        // first capture after reset release
        push(8'h01, 16'h1234, 3'd0);
        rst_n = 1'b1; req = 8'h01; din[15:0] = 16'h1234; out_ready = 1'b1;
        cyc();
        req = 8'h00;
        cyc();
        @(negedge clk);
        chk("drain_empty", 32'(out_valid), 32'd0);
        // full round-robin sweep with back-to-back captures
        do_reset();
        for (int i = 0; i < 8; i++) din[16*i +: 16] = 16'h00A0 + 16'(i);
        for (int i = 0; i < 9; i++) push(8'd1 << (i % 8), 16'h00A0 + 16'(i % 8), 3'(i % 8));
        req = 8'hFF; out_ready = 1'b1;
        repeat (9) cyc();
        chk("sweep_no_idle", 32'(q.size()), 32'd0);
        // stall while full
        req = 8'h0C; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ack", 32'(ack), 32'd0);
            chk("stall_data", 32'(out_data), 32'h00A0);
        end
        cyc();
        push(8'h04, 16'h00A2, 3'd2);
        out_ready = 1'b1;
        cyc();
        req = 8'h00;
        cyc();
        // wrap-around
        do_reset();
        din[15:0] = 16'h1111; din[127:112] = 16'h7777;
        push(8'h01, 16'h1111, 3'd0);
        push(8'h80, 16'h7777, 3'd7);
        push(8'h01, 16'h1111, 3'd0);
        req = 8'h81; out_ready = 1'b1;
        repeat (3) cyc();
        req = 8'h00;
        cyc();
        // lock behaviour
        do_reset();
        din[31:16] = 16'h0101; din[47:32] = 16'h0202;
`ifdef ARB_LOCK_EN
        exp_sel = '{1, 1, 1, 1, 2};
`else
        exp_sel = '{1, 2, 1, 2, 1};
`endif
        for (int i = 0; i < 5; i++)
            push(8'd1 << exp_sel[i], (exp_sel[i] == 1) ? 16'h0101 : 16'h0202, 3'(exp_sel[i]));
        req = 8'h06; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lock = (i < 3) ? 8'h02 : 8'h00;
            cyc();
        end
        req = 8'h00; lock = 8'h00;
        cyc();
        // reset mid-transfer
        do_reset();
        din[95:80] = 16'hBEEF;
        push(8'h20, 16'hBEEF, 3'd5);
        req = 8'h20; out_ready = 1'b0;
        cyc();
        req = 8'h00;
        cyc();
        #2;
        rst_n = 1'b0;
        req = 8'h41; din[15:0] = 16'h0A0A; din[111:96] = 16'h0606;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        cyc();
        push(8'h01, 16'h0A0A, 3'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        cyc();
        req = 8'h00;
        repeat (2) cyc();
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("no_pending", 32'(pend), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
